gearbox_up_param: RTL and testbench

//  Parametrised narrow-to-wide bit gearbox: packs IN_W-bit words into OUT_W-bit words (OUT_W >= IN_W).

---
 rtl/gearbox_up_param.sv | 72 +++++++
 tb/tb_gearbox_up_param.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/gearbox_up_param.sv
// Narrow-to-wide bit gearbox: packs IN_W-bit words into OUT_W-bit words, LSB-first,
// with gapped input and a runtime bitslip for word alignment.
module gearbox_up_param #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 22,
  localparam int SA_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1,
  localparam int BUF_W = IN_W + OUT_W,
  localparam int CNT_W = $clog2(BUF_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IN_W-1:0]  din,
  input  logic             din_valid,
  input  logic             slip,
  input  logic [SA_W-1:0]  slip_amt,
  output logic [OUT_W-1:0] dout,
  output logic             dout_valid,
  output logic             slip_rej,
  output logic [CNT_W-1:0] fill
);

  logic [BUF_W-1:0] buffer;
  logic [BUF_W-1:0] buf_slip, buf_acc, buf_next;
  logic [CNT_W-1:0] slip_len, c1, c2, fill_next;
  logic             slip_ok, slip_bad, emit;

  // Slip, then accept, then emit, all evaluated against the current fill.
  // Right shifts pull zeros in from the top, so bits above the fill stay clear.
  always_comb begin
    slip_len  = CNT_W'(slip_amt);
    slip_ok   = slip && (slip_len <= fill);
    slip_bad  = slip && (slip_len > fill);
    buf_slip  = buffer;
    c1        = fill;
    if (slip_ok) begin
      buf_slip = buffer >> slip_amt;
      c1       = fill - slip_len;
    end
    buf_acc = buf_slip;
    c2      = c1;
    if (din_valid) begin
      buf_acc = buf_slip | (BUF_W'(din) << c1);
      c2      = c1 + CNT_W'(IN_W);
    end
    emit      = (c2 >= CNT_W'(OUT_W));
    buf_next  = buf_acc;
    fill_next = c2;
    if (emit) begin
      buf_next  = buf_acc >> OUT_W;
      fill_next = c2 - CNT_W'(OUT_W);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buffer     <= '0;
      fill       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      slip_rej   <= 1'b0;
    end else begin
      buffer     <= buf_next;
      fill       <= fill_next;
      dout_valid <= emit;
      slip_rej   <= slip_bad;
      if (emit) begin
        dout <= buf_acc[OUT_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_gearbox_up_param.sv
// Scoreboard bench for gearbox_up_param: a bit-queue reference model predicts every
// output word, fill and slip rejection; expected words are queued and popped on strobes.
module tb_gearbox_up_param;

  localparam int IN_W  = 20;
  localparam int OUT_W = 22;
  localparam int SA_W  = $clog2(OUT_W);
  localparam int CNT_W = $clog2(IN_W + OUT_W + 1);
  localparam int NBITS = 220;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [IN_W-1:0]  din;
  logic             din_valid;
  logic             slip;
  logic [SA_W-1:0]  slip_amt;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             slip_rej;
  logic [CNT_W-1:0] fill;

  gearbox_up_param #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_valid  (din_valid),
    .slip       (slip),
    .slip_amt   (slip_amt),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slip_rej   (slip_rej),
    .fill       (fill)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic             bitQ[$];
  logic [OUT_W-1:0] expQ[$];
  logic [OUT_W-1:0] lastExp;
  logic             eValid, eRej;
  int               eFill;
  logic [NBITS-1:0] stream;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [IN_W-1:0] streamWord(input int k);
    return stream[k*IN_W +: IN_W];
  endfunction

  // Drive one cycle, advance the reference model, then check after the edge.
  task automatic applyStimulus(input logic rn, input logic v, input logic s,
                               input logic [SA_W-1:0] a, input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] w;
    rst_n = rn; din_valid = v; slip = s; slip_amt = a; din = d;
    if (!rn) begin
      bitQ.delete();
      expQ.delete();
      lastExp = '0; eValid = 1'b0; eRej = 1'b0;
    end else begin
      eRej   = 1'b0;
      eValid = 1'b0;
      if (s) begin
        if (int'(a) <= bitQ.size()) begin
          for (int i = 0; i < int'(a); i++) void'(bitQ.pop_front());
        end else begin
          eRej = 1'b1;
        end
      end
      if (v) for (int i = 0; i < IN_W; i++) bitQ.push_back(d[i]);
      if (bitQ.size() >= OUT_W) begin
        for (int i = 0; i < OUT_W; i++) w[i] = bitQ.pop_front();
        expQ.push_back(w);
        eValid = 1'b1;
      end
    end
    eFill = bitQ.size();
    @(posedge clk);
    #1;
    checkOutput("dout_valid", 64'(dout_valid), 64'(eValid));
    checkOutput("slip_rej", 64'(slip_rej), 64'(eRej));
    checkOutput("fill", 64'(fill), 64'(eFill));
    if (dout_valid) begin
      if (expQ.size() == 0) begin
        checkOutput("sb_unexpected_word", 64'(dout), 64'hDEAD);
      end else begin
        lastExp = expQ.pop_front();
        checkOutput("dout", 64'(dout), 64'(lastExp));
      end
    end else begin
      checkOutput("dout_hold", 64'(dout), 64'(lastExp));
    end
  endtask

  task automatic idle();
    applyStimulus(1'b1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    for (int i = 0; i < NBITS; i++) stream[i] = 1'((i / 8) >> (i % 8));
    rst_n = 1'b0; din_valid = 1'b0; slip = 1'b0; slip_amt = '0; din = '0;
    lastExp = '0; eValid = 1'b0; eRej = 1'b0; eFill = 0;

    // Reset state
    doReset();
    doReset();
    checkOutput("rst_dout", 64'(dout), 64'd0);

    // Continuous stream: fill walks 20,18,...,0
    for (int k = 0; k < 11; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(k));
      checkOutput("t1_fill_seq", 64'(fill), 64'(22 - 2 * (k + 1)));
      if (k >= 1) checkOutput("t1_word", 64'(dout), 64'(stream[(k-1)*OUT_W +: OUT_W]));
    end
    idle();

    // Gapped stream
    doReset();
    for (int k = 0; k < 11; ) begin
      if ($urandom_range(1) == 1) begin
        applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(k));
        k++;
      end else begin
        applyStimulus(1'b1, 1'b0, 1'b0, '0, 20'hABCDE);
      end
    end
    idle();

    // Slip refused on an empty buffer
    doReset();
    applyStimulus(1'b1, 1'b0, 1'b1, SA_W'(2), '0);
    checkOutput("t3_rej", 64'(slip_rej), 64'd1);
    checkOutput("t3_fill", 64'(fill), 64'd0);
    idle();
    checkOutput("t3_rej_clear", 64'(slip_rej), 64'd0);
    for (int k = 0; k < 11; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(k));

    // One-bit slip at fill 18
    doReset();
    applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(0));
    applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(1));
    applyStimulus(1'b1, 1'b0, 1'b1, SA_W'(1), '0);
    checkOutput("t4_fill", 64'(fill), 64'd17);
    for (int k = 2; k < 11; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(k));
      if (dout_valid) checkOutput("t4_shift", 64'(dout), 64'(stream[(k-1)*OUT_W + 1 +: OUT_W]));
    end

    // Slip and din together at fill 4
    doReset();
    for (int k = 0; k < 9; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(k));
    checkOutput("t5_fill_pre", 64'(fill), 64'd4);
    applyStimulus(1'b1, 1'b1, 1'b1, SA_W'(3), streamWord(9));
    checkOutput("t5_fill", 64'(fill), 64'd21);
    checkOutput("t5_valid", 64'(dout_valid), 64'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(10));
    checkOutput("t5_valid2", 64'(dout_valid), 64'd1);
    checkOutput("t5_fill2", 64'(fill), 64'd19);

    // Reset mid-stream at fill 10 with din_valid high
    doReset();
    for (int k = 0; k < 6; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(k));
    checkOutput("t6_fill_pre", 64'(fill), 64'd10);
    applyStimulus(1'b0, 1'b1, 1'b0, '0, streamWord(6));
    checkOutput("t6_dout", 64'(dout), 64'd0);
    checkOutput("t6_fill", 64'(fill), 64'd0);
    for (int k = 0; k < 11; k++) applyStimulus(1'b1, 1'b1, 1'b0, '0, streamWord(k));
    checkOutput("t6_realign", 64'(dout), 64'(stream[9*OUT_W +: OUT_W]));

    // Random data, gaps and slips
    doReset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'b1, 1'($urandom_range(1)), ($urandom_range(7) == 0),
                    SA_W'($urandom_range(OUT_W - 1)), IN_W'($urandom));
    end
    idle();
    checkOutput("sb_drained", 64'(expQ.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
